// File: rtl/uart_pkg.sv
// Shared UART constants and helpers: default clocking, the reset-divisor
// rounding function and the oversample-counter width.
package uart_pkg;

  localparam int DEF_CLK_FREQ   = 50_000_000;
  localparam int DEF_BAUD_RATE  = 9600;
  localparam int DEF_OVERSAMPLE = 16;

  function automatic int os_cnt_width(input int oversample);
    return (oversample > 1) ? $clog2(oversample) : 1;
  endfunction

  localparam int OS_CNT_W = os_cnt_width(DEF_OVERSAMPLE);

  // Rounded clk_freq * 2^frac_w / (baud_rate * oversample).
  function automatic logic [63:0] reset_divisor(input int clk_freq,
                                                input int baud_rate,
                                                input int oversample,
                                                input int frac_w);
    logic [63:0] num;
    logic [63:0] den;
    num = 64'(clk_freq) << frac_w;
    den = 64'(baud_rate) * 64'(oversample);
    return (num + (den >> 1)) / den;
  endfunction

endpackage

// File: rtl/baud_frac_acc.sv
// Fractional accumulator step for baud_gen_frac: adds the fractional divisor
// to the running remainder and reports the carry that stretches a period.
module baud_frac_acc #(
  parameter int FRAC_W = 4
) (
  input  logic [FRAC_W-1:0] acc,
  input  logic [FRAC_W-1:0] frac,
  output logic              carry,
  output logic [FRAC_W-1:0] acc_next
);

  logic [FRAC_W:0] sum;

  assign sum      = {1'b0, acc} + {1'b0, frac};
  assign carry    = sum[FRAC_W];
  assign acc_next = sum[FRAC_W-1:0];

endmodule

// File: rtl/baud_gen_frac.sv
// Fractional-N baud generator: oversample, mid-bit and bit ticks from clk.
// Define BAUD_GEN_FRAC_EN to enable fractional accumulation.
module baud_gen_frac
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = DEF_CLK_FREQ,
  parameter int BAUD_RATE  = DEF_BAUD_RATE,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int INT_W      = 16,
  parameter int FRAC_W     = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              restart,
  input  logic              div_wr,
  input  logic [INT_W-1:0]  div_int_in,
  input  logic [FRAC_W-1:0] div_frac_in,
  output logic [INT_W-1:0]  div_int,
  output logic [FRAC_W-1:0] div_frac,
  output logic              div_pending,
  output logic              os_tick,
  output logic              mid_tick,
  output logic              bit_tick
);

  localparam int OS_W = os_cnt_width(OVERSAMPLE);
`ifdef BAUD_GEN_FRAC_EN
  localparam int FRAC_SH = FRAC_W;
`else
  localparam int FRAC_SH = 0;
`endif
  localparam logic [63:0]      RST_DIV = reset_divisor(CLK_FREQ, BAUD_RATE, OVERSAMPLE, FRAC_SH);
  localparam logic [INT_W-1:0] RST_INT = INT_W'(RST_DIV >> FRAC_SH);
  localparam logic [OS_W-1:0]  OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [INT_W:0]   ONE     = (INT_W + 1)'(1);

  logic [INT_W:0]     cyc_cnt;
  logic [INT_W:0]     cur_period;
  logic [OS_W-1:0]    os_cnt;
  logic [INT_W-1:0]   shadow_int;
  logic [INT_W-1:0]   apply_int;
  logic [INT_W-1:0]   restart_int;
  logic               boundary;
  logic               period_carry;

  // NOTE: every combinational output gets a default at the top of the block,
  // so no path through it can leave a value unassigned and infer a latch.
  always_comb begin
    apply_int   = div_pending ? shadow_int : div_int;
    restart_int = div_wr ? div_int_in : apply_int;
    boundary    = (cyc_cnt == cur_period - ONE);
  end

`ifdef BAUD_GEN_FRAC_EN
  localparam logic [FRAC_W-1:0] RST_FRAC = FRAC_W'(RST_DIV);

  logic [FRAC_W-1:0] frac_acc;
  logic [FRAC_W-1:0] shadow_frac;
  logic [FRAC_W-1:0] apply_frac;
  logic [FRAC_W-1:0] restart_frac;
  logic [FRAC_W-1:0] acc_next;

  always_comb begin
    apply_frac   = div_pending ? shadow_frac : div_frac;
    restart_frac = div_wr ? div_frac_in : apply_frac;
  end

  // The carry is taken against the divisor that becomes active at this boundary.
  baud_frac_acc #(.FRAC_W(FRAC_W)) u_frac_acc (
    .acc      (frac_acc),
    .frac     (apply_frac),
    .carry    (period_carry),
    .acc_next (acc_next)
  );
`else
  logic unused_frac_in;

  assign period_carry   = 1'b0;
  assign div_frac       = '0;
  assign unused_frac_in = ^div_frac_in;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc_cnt     <= '0;
      cur_period  <= {1'b0, RST_INT};
      os_cnt      <= '0;
      div_int     <= RST_INT;
      shadow_int  <= RST_INT;
      div_pending <= 1'b0;
      os_tick     <= 1'b0;
      mid_tick    <= 1'b0;
      bit_tick    <= 1'b0;
`ifdef BAUD_GEN_FRAC_EN
      frac_acc    <= '0;
      div_frac    <= RST_FRAC;
      shadow_frac <= RST_FRAC;
`endif
    end else begin
      os_tick  <= 1'b0;
      mid_tick <= 1'b0;
      bit_tick <= 1'b0;
      if (restart) begin
        cyc_cnt     <= '0;
        os_cnt      <= '0;
        div_pending <= 1'b0;
        div_int     <= restart_int;
        shadow_int  <= restart_int;
        cur_period  <= {1'b0, restart_int};
`ifdef BAUD_GEN_FRAC_EN
        frac_acc    <= '0;
        div_frac    <= restart_frac;
        shadow_frac <= restart_frac;
`endif
      end else begin
        if (div_wr) begin
          shadow_int  <= div_int_in;
          div_pending <= 1'b1;
`ifdef BAUD_GEN_FRAC_EN
          shadow_frac <= div_frac_in;
`endif
        end
        if (div_int == '0) begin
          // Halted: only a pending divisor can wake the generator, even with en low.
          if (div_pending) begin
            div_int    <= shadow_int;
            cur_period <= {1'b0, shadow_int};
`ifdef BAUD_GEN_FRAC_EN
            div_frac   <= shadow_frac;
`endif
            if (!div_wr) div_pending <= 1'b0;
          end
        end else if (en) begin
          if (boundary) begin
            cyc_cnt    <= '0;
            os_tick    <= 1'b1;
            mid_tick   <= (os_cnt == OS_MID);
            bit_tick   <= (os_cnt == OS_LAST);
            os_cnt     <= (os_cnt == OS_LAST) ? '0 : os_cnt + 1'b1;
            div_int    <= apply_int;
            cur_period <= {1'b0, apply_int} + {{INT_W{1'b0}}, period_carry};
`ifdef BAUD_GEN_FRAC_EN
            div_frac   <= apply_frac;
            frac_acc   <= acc_next;
`endif
            if (!div_wr) div_pending <= 1'b0;
          end else begin
            cyc_cnt <= cyc_cnt + ONE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_baud_gen_frac.sv
// Scoreboard bench for baud_gen_frac: stimulus pushes expected tick events,
// a negedge monitor pops and compares each os_tick the DUT presents.
module tb_baud_gen_frac;

`ifdef BAUD_GEN_FRAC_EN
  localparam int RST_INT  = 325;
  localparam int RST_FRAC = 8;
  localparam int SPAN     = 10416;
`else
  localparam int RST_INT  = 326;
  localparam int RST_FRAC = 0;
  localparam int SPAN     = 10432;
`endif
  localparam int OS = 16;

  typedef struct {
    int   cyc;
    logic mid;
    logic bt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en;
  logic        restart;
  logic        div_wr;
  logic [15:0] div_int_in;
  logic [3:0]  div_frac_in;
  logic [15:0] div_int;
  logic [3:0]  div_frac;
  logic        div_pending;
  logic        os_tick;
  logic        mid_tick;
  logic        bit_tick;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  int   tick_log[$];

  // Reference model state: cycle of last boundary, current period, accumulator.
  int m_cyc, m_period, m_acc, m_os, m_int, m_frac;

  baud_gen_frac #(
    .CLK_FREQ(50000000), .BAUD_RATE(9600), .OVERSAMPLE(16), .INT_W(16), .FRAC_W(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .restart(restart), .div_wr(div_wr),
    .div_int_in(div_int_in), .div_frac_in(div_frac_in), .div_int(div_int),
    .div_frac(div_frac), .div_pending(div_pending), .os_tick(os_tick),
    .mid_tick(mid_tick), .bit_tick(bit_tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: cycle %0d reached, required completion earlier", cyc);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every os_tick must match the oldest expected event.
  always @(negedge clk) begin
    if (reset_n) begin
      if (os_tick) begin
        tick_log.push_back(cyc);
        if (sb.size() == 0) begin
          check("unexpected_os_tick", os_tick, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("tick_cycle", cyc, e.cyc);
          check("mid_tick", mid_tick, e.mid);
          check("bit_tick", bit_tick, e.bt);
        end
      end else begin
        if (mid_tick) check("mid_without_os", mid_tick, 0);
        if (bit_tick) check("bit_without_os", bit_tick, 0);
      end
    end
  end

  task automatic expect_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      int   sum;
      m_cyc += m_period;
      e.cyc = m_cyc;
      e.mid = (m_os == OS / 2 - 1);
      e.bt  = (m_os == OS - 1);
      m_os  = (m_os == OS - 1) ? 0 : m_os + 1;
`ifdef BAUD_GEN_FRAC_EN
      sum      = m_acc + m_frac;
      m_period = m_int + sum / 16;
      m_acc    = sum % 16;
`else
      sum      = 0;
      m_period = m_int + sum;
`endif
      sb.push_back(e);
    end
  endtask

  task automatic goto(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic write_div(input int i, input int f);
    div_wr      = 1'b1;
    div_int_in  = 16'(i);
    div_frac_in = 4'(f);
    @(negedge clk);
    div_wr = 1'b0;
  endtask

  task automatic model_restart(input int at);
    m_cyc = at; m_period = m_int; m_acc = 0; m_os = 0;
  endtask

  initial begin
    int e_cyc, r_cyc, h;
    reset_n = 1'b0; en = 1'b0; restart = 1'b0; div_wr = 1'b0;
    div_int_in = '0; div_frac_in = '0;
    repeat (3) @(negedge clk);
    check("rst_os_tick", os_tick, 0);
    check("rst_mid_tick", mid_tick, 0);
    check("rst_bit_tick", bit_tick, 0);
    check("rst_div_int", div_int, RST_INT);
    check("rst_div_frac", div_frac, RST_FRAC);
    check("rst_div_pending", div_pending, 0);

    // Release with en high: first tick after RST_INT edges, then the fractional cadence.
    reset_n = 1'b1; en = 1'b1;
    tick_log.delete();
    m_int = RST_INT; m_frac = RST_FRAC;
    model_restart(cyc);
    h = cyc;
    expect_ticks(34);
    goto(m_cyc + 1);
    check("tick_count_34", tick_log.size(), 34);
    if (tick_log.size() >= 34) begin
      check("first_tick_latency", tick_log[0] - h, RST_INT);
      check("span_ticks_2_34", tick_log[33] - tick_log[1], SPAN);
    end

    // Mid-period write: old period finishes, then 10-cycle periods.
    goto(m_cyc + 50);
    write_div(10, 0);
    check("wr_pending_set", div_pending, 1);
    check("wr_old_div_int", div_int, RST_INT);
    m_int = 10; m_frac = 0;
    expect_ticks(1);
    goto(m_cyc + 1);
    check("wr_pending_clr", div_pending, 0);
    check("wr_new_div_int", div_int, 10);
    expect_ticks(2);

    // Write coincident with a boundary stays pending one more period.
    e_cyc = m_cyc + m_period;
    goto(e_cyc - 1);
    write_div(12, 0);
    expect_ticks(1);
    goto(e_cyc + 1);
    check("coinc_pending_held", div_pending, 1);
    check("coinc_div_int_old", div_int, 10);
    m_int = 12;
    expect_ticks(1);
    goto(m_cyc + 1);
    check("coinc_pending_clr", div_pending, 0);
    check("coinc_div_int_new", div_int, 12);
    expect_ticks(3);
    goto(m_cyc + 1);

    // restart with a same-cycle write applies the divisor directly.
    restart = 1'b1; div_wr = 1'b1;
    div_int_in = 16'(RST_INT); div_frac_in = 4'(RST_FRAC);
    @(negedge clk);
    restart = 1'b0; div_wr = 1'b0;
    check("restart_div_int", div_int, RST_INT);
    check("restart_pending", div_pending, 0);
    m_int = RST_INT; m_frac = RST_FRAC;
    model_restart(cyc);
    expect_ticks(5);

    // restart at os_cnt=5 on the edge that would have ticked.
    r_cyc = m_cyc + m_period;
    goto(r_cyc - 1);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("restart_tick_forced_0", os_tick, 0);
    model_restart(r_cyc);
    expect_ticks(16);
    goto(m_cyc + 1);

    // en low for 100 cycles stretches the period by 100; div_wr still accepted.
    goto(m_cyc + 20);
    en = 1'b0;
    repeat (50) @(negedge clk);
    write_div(RST_INT, RST_FRAC);
    check("en_low_wr_pending", div_pending, 1);
    repeat (49) @(negedge clk);
    en = 1'b1;
    m_cyc += 100;
    expect_ticks(1);
    goto(m_cyc + 1);
    check("en_low_pending_clr", div_pending, 0);
    expect_ticks(2);
    goto(m_cyc + 1);

    // div_int = 0 halts; a later write wakes it even with en low.
    goto(m_cyc + 5);
    write_div(0, 0);
    m_int = 0; m_frac = 0;
    expect_ticks(1);
    goto(m_cyc + 1);
    check("halt_div_int", div_int, 0);
    repeat (300) @(negedge clk);
    en = 1'b0;
    write_div(1, 0);
    @(negedge clk);
    check("halt_wake_div_int", div_int, 1);
    check("halt_wake_pending", div_pending, 0);
    en = 1'b1;
    m_int = 1; m_cyc = cyc; m_period = 1;
    expect_ticks(40);
    goto(m_cyc);

    // Asynchronous reset while os_tick is high.
    #2;
    check("sb_drained", sb.size(), 0);
    reset_n = 1'b0;
    #1;
    check("async_rst_os_tick", os_tick, 0);
    check("async_rst_div_int", div_int, RST_INT);
    check("async_rst_div_frac", div_frac, RST_FRAC);
    check("async_rst_pending", div_pending, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
